ahb_rr_arbiter: RTL

- AHB bus arbiter for the AXI3-AHB bench fabric.
- Shares one AHB address/data bus between up to NUM_MASTERS requesting masters using round-robin fairness.
- Respects fixed-length burst boundaries and locked sequences.
- Drives the grant vector plus the registered address-phase and data-phase owner indices that steer the HADDR/HWDATA muxes.

---
 rtl/ahb_rr_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_rr_arbiter
//   Round-robin AHB bus arbiter. Up to NUM_MASTERS masters share one
//   address/data bus. The arbiter never splits a fixed-length burst and
//   never takes the bus from a master that holds a locked sequence. It also
//   drives the registered address-phase and data-phase owner indices that
//   steer the HADDR/HWDATA muxes.
//
//   Optional build macro: AHB_ARB_INCR_HOLD_EN
//     When defined, SEQ beats of an INCR (undefined-length) burst are not
//     arbitration points. A hold counter forces a handover after
//     MAX_INCR_BEATS accepted SEQ beats, so one master cannot keep the bus
//     indefinitely.
//
// Ports
//   clk          in   bus clock
//   rst          in   synchronous active-high reset
//   hbusreq      in   [NUM_MASTERS]     per-master bus request
//   hlock        in   [NUM_MASTERS]     per-master locked-access request
//   htrans       in   [2]               muxed HTRANS
//   hburst       in   [3]               muxed HBURST
//   hready       in   1                 muxed HREADY
//   hgrant       out  [NUM_MASTERS]     one-hot grant, registered
//   hmaster      out  [NUM_MASTER_BITS] address-phase owner
//   hmaster_data out  [NUM_MASTER_BITS] data-phase owner
//   hmastlock    out  1                 current address phase is locked
// ---------------------------------------------------------------------------
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int NUM_MASTER_BITS = 2,
  parameter int DEFAULT_MASTER  = 0,
  parameter int MAX_INCR_BEATS  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_MASTERS-1:0]     hbusreq,
  input  logic [NUM_MASTERS-1:0]     hlock,
  input  logic [1:0]                 htrans,
  input  logic [2:0]                 hburst,
  input  logic                       hready,
  output logic [NUM_MASTERS-1:0]     hgrant,
  output logic [NUM_MASTER_BITS-1:0] hmaster,
  output logic [NUM_MASTER_BITS-1:0] hmaster_data,
  output logic                       hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [NUM_MASTER_BITS-1:0] DEF_IDX = NUM_MASTER_BITS'(DEFAULT_MASTER);

  // One-hot vector with bit idx set.
  function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic [NUM_MASTER_BITS-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v = {NUM_MASTERS{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Index of the set bit in a one-hot vector.
  function automatic logic [NUM_MASTER_BITS-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [NUM_MASTER_BITS-1:0] idx;
    idx = {NUM_MASTER_BITS{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) begin
        idx = NUM_MASTER_BITS'(i);
      end
    end
    return idx;
  endfunction

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = idx_to_onehot(DEF_IDX);

  logic [NUM_MASTERS-1:0]     grant_q, grant_d;
  logic [NUM_MASTER_BITS-1:0] ptr_q, ptr_d;
  logic [NUM_MASTER_BITS-1:0] hmaster_q, hmaster_data_q;
  logic                       hmastlock_q;
  logic [3:0]                 cnt_q, cnt_d;

  logic [NUM_MASTER_BITS-1:0] gidx_s;
  logic [NUM_MASTER_BITS-1:0] winner_s;
  logic [NUM_MASTER_BITS-1:0] cand_s;
  logic                       any_req_s;
  logic [3:0]                 len_m1_s;
  logic                       fixed_s;
  logic                       single_s;
  logic                       incr_s;
  logic                       last_beat_s;
  logic                       hold_hit_s;
  logic                       arb_base_s;
  logic                       lock_hold_s;
  logic                       arb_ok_s;

  assign gidx_s   = onehot_to_idx(grant_q);
  assign fixed_s  = (hburst[2:1] != 2'b00);
  assign single_s = (hburst == 3'b000);
  assign incr_s   = (hburst == 3'b001);

  // Burst length minus one for the beat counter load on NONSEQ.
  always_comb begin
    len_m1_s = 4'd0;
    case (hburst[2:1])
      2'b01:   len_m1_s = 4'd3;
      2'b10:   len_m1_s = 4'd7;
      2'b11:   len_m1_s = 4'd15;
      default: len_m1_s = 4'd0;
    endcase
  end

  // Beat counter: load on NONSEQ, saturating decrement on SEQ, hold on IDLE/BUSY.
  always_comb begin
    cnt_d = cnt_q;
    if (htrans == TR_NONSEQ) begin
      cnt_d = len_m1_s;
    end else if (htrans == TR_SEQ) begin
      cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Last beat of a fixed-length burst; NONSEQ with length 1 cannot occur for
  // fixed bursts but is kept so the rule reads as a whole.
  assign last_beat_s = fixed_s &&
                       (((htrans == TR_NONSEQ) && (len_m1_s == 4'd0)) ||
                        ((htrans == TR_SEQ) && (cnt_q == 4'd1)));

`ifdef AHB_ARB_INCR_HOLD_EN
  localparam int HW = $clog2(MAX_INCR_BEATS + 1);
  logic [HW-1:0] hold_q, hold_d;

  // The beat that brings the hold count to the limit is a forced handover point.
  assign hold_hit_s = (htrans == TR_SEQ) && (hold_q == HW'(MAX_INCR_BEATS - 1));

  // Hold counter: counts accepted SEQ beats, clears at the limit and on NONSEQ/IDLE.
  always_comb begin
    hold_d = hold_q;
    if ((htrans == TR_NONSEQ) || (htrans == TR_IDLE)) begin
      hold_d = {HW{1'b0}};
    end else if (htrans == TR_SEQ) begin
      hold_d = hold_hit_s ? {HW{1'b0}} : hold_q + HW'(1);
    end else begin
      hold_d = hold_q;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= {HW{1'b0}};
    end else if (hready) begin
      hold_q <= hold_d;
    end
  end

  // INCR SEQ beats keep the bus with the current owner.
  assign arb_base_s = (htrans == TR_IDLE) ||
                      (single_s && htrans[1]) ||
                      (incr_s && (htrans == TR_NONSEQ)) ||
                      last_beat_s || hold_hit_s;
`else
  assign hold_hit_s = 1'b0;

  // SINGLE and INCR beats are all arbitration points.
  assign arb_base_s = (htrans == TR_IDLE) ||
                      ((single_s || incr_s) && htrans[1]) ||
                      last_beat_s || hold_hit_s;
`endif

  assign lock_hold_s = hlock[gidx_s] && hbusreq[gidx_s];
  assign arb_ok_s    = arb_base_s && !lock_hold_s;

  // Round-robin scan from pointer+1 around to the pointer itself.
  always_comb begin
    winner_s  = DEF_IDX;
    any_req_s = 1'b0;
    cand_s    = ptr_q;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand_s = NUM_MASTER_BITS'((int'(ptr_q) + i) % NUM_MASTERS);
      if (!any_req_s && hbusreq[cand_s]) begin
        winner_s  = cand_s;
        any_req_s = 1'b1;
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  // Next grant and pointer; the pointer only moves on a real request.
  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (arb_ok_s) begin
      grant_d = idx_to_onehot(winner_s);
      ptr_d   = any_req_s ? winner_s : ptr_q;
    end else begin
      grant_d = grant_q;
      ptr_d   = ptr_q;
    end
  end

  // Arbiter state and ownership pipeline; everything freezes while hready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q        <= DEF_GRANT;
      ptr_q          <= DEF_IDX;
      cnt_q          <= 4'd0;
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
      hmastlock_q    <= 1'b0;
    end else if (hready) begin
      grant_q        <= grant_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      hmaster_q      <= gidx_s;
      hmaster_data_q <= hmaster_q;
      hmastlock_q    <= hlock[gidx_s];
    end
  end

  assign hgrant       = grant_q;
  assign hmaster      = hmaster_q;
  assign hmaster_data = hmaster_data_q;
  assign hmastlock    = hmastlock_q;

endmodule
